// File: rtl/dwconv_engine.sv
// Streaming depthwise 3x3 convolution (stride 1, zero padding) over raster, channel-minor samples.
// A sliding window of 2*(IMG_W+1)*CHANNELS+1 samples holds every neighbour of the pixel being emitted.
module dwconv_engine #(
    parameter int CHANNELS  = 256,
    parameter int IMG_W     = 14,
    parameter int IMG_H     = 14,
    parameter int FRAC_BITS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [15:0]  in_data,
    input  logic [15:0]  bias,
    input  logic [143:0] weight,
    output logic         out_valid,
    output logic [20:0]  sum
);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LAG   = (IMG_W + 1) * CHANNELS;
    localparam int DEPTH = 2 * LAG + 1;

    // Handshake: a sample is taken on every rising edge with in_valid=1 outside FLUSH (no
    // backpressure); out_valid is a per-result strobe and sum holds its value otherwise.
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_next;

    logic [CW-1:0] in_ch, out_ch;
    logic [XW-1:0] in_col, out_col;
    logic [YW-1:0] in_row, out_row;
    logic          accept, emit, shift;
    logic          in_fill_end, in_last, out_last;

    logic [15:0]   line [DEPTH-1];
    logic [15:0]   win [DEPTH];
    logic [143:0]  w_store [2**CW];
    logic [15:0]   b_store [2**CW];
    logic [143:0]  w_sel;
    logic [15:0]   b_sel;
    logic signed [35:0] acc, shifted;
    logic [20:0]   sat;
    logic          row_ok, col_ok;

    assign in_fill_end = (in_row == YW'(1)) && (in_col == '0) && (in_ch == CW'(CHANNELS - 1));
    assign in_last  = (in_row == YW'(IMG_H - 1)) && (in_col == XW'(IMG_W - 1)) && (in_ch == CW'(CHANNELS - 1));
    assign out_last = (out_row == YW'(IMG_H - 1)) && (out_col == XW'(IMG_W - 1)) && (out_ch == CW'(CHANNELS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = FILL;
            FILL:    if (accept && in_fill_end) state_next = RUN;
            RUN:     if (accept && in_last) state_next = FLUSH;
            FLUSH:   if (out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = in_valid && (state != FLUSH);
        emit   = (state == FLUSH) || ((state == RUN) && in_valid);
        shift  = accept || (state == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ch   <= '0;
            in_col  <= '0;
            in_row  <= '0;
            out_ch  <= '0;
            out_col <= '0;
            out_row <= '0;
        end else begin
            if (accept) begin
                if (in_ch == CW'(CHANNELS - 1)) begin
                    in_ch <= '0;
                    if (in_col == XW'(IMG_W - 1)) begin
                        in_col <= '0;
                        in_row <= (in_row == YW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
                    end else begin
                        in_col <= in_col + 1'b1;
                    end
                end else begin
                    in_ch <= in_ch + 1'b1;
                end
            end
            if (emit) begin
                if (out_ch == CW'(CHANNELS - 1)) begin
                    out_ch <= '0;
                    if (out_col == XW'(IMG_W - 1)) begin
                        out_col <= '0;
                        out_row <= (out_row == YW'(IMG_H - 1)) ? '0 : out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                end else begin
                    out_ch <= out_ch + 1'b1;
                end
            end
        end
    end

    // Window storage carries no reset: out-of-map neighbours are masked by index, not cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            w_store[in_ch] <= weight;
            b_store[in_ch] <= bias;
        end
        if (shift) begin
            for (int j = 0; j < DEPTH - 1; j++) line[j] <= win[j];
        end
    end

    always_comb begin
        win[0] = accept ? in_data : '0;
        for (int j = 1; j < DEPTH; j++) win[j] = line[j-1];
    end

    // While accepting, the incoming sample shares the emitted pixel's channel, so its taps apply.
    assign w_sel = accept ? weight : w_store[out_ch];
    assign b_sel = accept ? bias : b_store[out_ch];

    function automatic logic signed [31:0] mul16(input logic signed [15:0] a, input logic signed [15:0] b);
        return a * b;
    endfunction

    always_comb begin
        row_ok = 1'b1;
        col_ok = 1'b1;
        acc    = 36'($signed(b_sel)) <<< FRAC_BITS;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                if (dy == 0)      row_ok = (out_row != '0);
                else if (dy == 2) row_ok = (out_row != YW'(IMG_H - 1));
                else              row_ok = 1'b1;
                if (dx == 0)      col_ok = (out_col != '0);
                else if (dx == 2) col_ok = (out_col != XW'(IMG_W - 1));
                else              col_ok = 1'b1;
                if (row_ok && col_ok)
                    acc = acc + 36'(mul16(win[((2 - dy) * IMG_W + (2 - dx)) * CHANNELS],
                                          w_sel[16*(3*dy+dx) +: 16]));
            end
        end
    end

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > 36'sd1048575)       sat = 21'h0FFFFF;
        else if (shifted < -36'sd1048576) sat = 21'h100000;
        else                              sat = shifted[20:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= emit;
            if (emit) sum <= sat;
        end
    end
endmodule

// File: tb/tb_dwconv_engine.sv
// Directed bench for dwconv_engine on 3x3 maps with 1, 2 and 4 channels sharing one stimulus bus.
module tb_dwconv_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         v1, v2, v4;
  logic [15:0]  in_data, bias;
  logic [143:0] weight;
  logic         ov1, ov2, ov4;
  logic [20:0]  s1, s2, s4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [20:0] got1[$], got2[$], got4[$];
  int          st1[$], st4[$];
  logic [20:0] exp_q[$];
  logic [15:0] frame_d [9];
  int          acc_st [9];
  int          nvalid [9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
  int          basic_exp [9] = '{1024, 1536, 1024, 1536, 2304, 1536, 1024, 1536, 1024};

  dwconv_engine #(.CHANNELS(1), .IMG_W(3), .IMG_H(3), .FRAC_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(in_data), .bias(bias),
    .weight(weight), .out_valid(ov1), .sum(s1));
  dwconv_engine #(.CHANNELS(2), .IMG_W(3), .IMG_H(3), .FRAC_BITS(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(in_data), .bias(bias),
    .weight(weight), .out_valid(ov2), .sum(s2));
  dwconv_engine #(.CHANNELS(4), .IMG_W(3), .IMG_H(3), .FRAC_BITS(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(in_data), .bias(bias),
    .weight(weight), .out_valid(ov4), .sum(s4));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov1) begin got1.push_back(s1); st1.push_back(cyc); end
    if (ov2) got2.push_back(s2);
    if (ov4) begin got4.push_back(s4); st4.push_back(cyc); end
  end

  task automatic clear_q();
    got1.delete(); st1.delete(); got2.delete(); got4.delete(); st4.delete(); exp_q.delete();
  endtask

  task automatic drive(input logic [2:0] sel, input logic [15:0] d, input logic [143:0] w,
                       input logic [15:0] b);
    @(posedge clk); #1;
    v1 = sel[0]; v2 = sel[1]; v4 = sel[2];
    in_data = d; weight = w; bias = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      1: return got1.size();
      2: return got2.size();
      default: return got4.size();
    endcase
  endfunction

  task automatic wait_out(input int which, input int n);
    for (int i = 0; i < 300; i++) begin
      if (qsize(which) >= n) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic send_frame1(input int gap, input logic [143:0] w, input logic [15:0] b);
    for (int i = 0; i < 9; i++) begin
      drive(3'b001, frame_d[i], w, b);
      acc_st[i] = cyc + 1;
      if (gap > 0 && i < 8) idle(gap);
    end
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    in_data = '0; bias = '0; weight = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1: got %b want 0", ov1); end
    checks++; if (s1 !== 21'd0) begin errors++; $display("FAIL reset_s1: got %0d want 0", s1); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2: got %b want 0", ov2); end
    checks++; if (s2 !== 21'd0) begin errors++; $display("FAIL reset_s2: got %0d want 0", s2); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %b want 0", ov4); end
    checks++; if (s4 !== 21'd0) begin errors++; $display("FAIL reset_s4: got %0d want 0", s4); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_frame_timing(input int gap, input string name);
    int want;
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = 16'h0100;
    send_frame1(gap, {9{16'h0100}}, 16'h0000);
    wait_out(1, 9);
    checks++;
    if (got1.size() != 9) begin errors++; $display("FAIL %s_count: got %0d want 9", name, got1.size()); end
    for (int p = 0; p < 9; p++) exp_q.push_back(21'(basic_exp[p]));
    for (int p = 0; p < 9; p++) begin
      logic [20:0] e, g;
      e = exp_q.pop_front();
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s_val[%0d]: got %0d want %0d", name, p, $signed(g), $signed(e)); end
      want = (p < 5) ? acc_st[p+4] : acc_st[8] + p - 4;
      checks++;
      if (p >= st1.size() || st1[p] != want) begin
        errors++;
        $display("FAIL %s_cycle[%0d]: got %0d want %0d", name, p, (p < st1.size()) ? st1[p] : -1, want);
      end
    end
    @(negedge clk);
    checks++;
    if (ov1 !== 1'b0 || s1 !== 21'd1024) begin
      errors++; $display("FAIL %s_hold: got valid=%b sum=%0d want valid=0 sum=1024", name, ov1, s1);
    end
  endtask

  task automatic test_taps();
    logic [143:0] w;
    for (int k = 0; k < 9; k++) w[16*k +: 16] = 16'((k + 1) * 256);
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = (i == 4) ? 16'h0100 : 16'h0000;
    send_frame1(0, w, 16'h0000);
    wait_out(1, 9);
    for (int p = 0; p < 9; p++) exp_q.push_back(21'(256 * (9 - p)));
    checks++;
    if (got1.size() != 9) begin errors++; $display("FAIL taps_count: got %0d want 9", got1.size()); end
    for (int p = 0; p < 9; p++) begin
      logic [20:0] e, g;
      e = exp_q.pop_front();
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL taps_val[%0d]: got %0d want %0d", p, $signed(g), $signed(e)); end
    end
    // Impulse on the right edge: a missing column mask would leak it into the next row's left pixel.
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = (i == 2) ? 16'h0100 : 16'h0000;
    send_frame1(0, {9{16'h0100}}, 16'h0000);
    wait_out(1, 9);
    for (int p = 0; p < 9; p++) exp_q.push_back((p == 1 || p == 2 || p == 4 || p == 5) ? 21'd256 : 21'd0);
    for (int p = 0; p < 9; p++) begin
      logic [20:0] e, g;
      e = exp_q.pop_front();
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL colmask_val[%0d]: got %0d want %0d", p, $signed(g), $signed(e)); end
    end
  endtask

  task automatic test_bias();
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = 16'($urandom_range(0, 65535));
    send_frame1(0, 144'd0, 16'h0100);
    wait_out(1, 9);
    checks++;
    if (got1.size() != 9) begin errors++; $display("FAIL bias1_count: got %0d want 9", got1.size()); end
    for (int p = 0; p < 9; p++) begin
      logic [20:0] g;
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== 21'd256) begin errors++; $display("FAIL bias1_val[%0d]: got %0d want 256", p, $signed(g)); end
    end
    for (int i = 0; i < 18; i++)
      drive(3'b010, 16'($urandom_range(0, 65535)), 144'd0, (i % 2 == 1) ? 16'hFF00 : 16'h0100);
    idle(1);
    wait_out(2, 18);
    for (int p = 0; p < 18; p++) exp_q.push_back((p % 2 == 1) ? 21'h1FFF00 : 21'd256);
    checks++;
    if (got2.size() != 18) begin errors++; $display("FAIL bias2_count: got %0d want 18", got2.size()); end
    for (int p = 0; p < 18; p++) begin
      logic [20:0] e, g;
      e = exp_q.pop_front();
      g = (p < got2.size()) ? got2[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL bias2_val[%0d]: got %0d want %0d", p, $signed(g), $signed(e)); end
    end
  endtask

  task automatic test_arith(input logic [15:0] d, input logic [15:0] t, input logic [20:0] e,
                            input string name);
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = d;
    send_frame1(0, {9{t}}, 16'h0000);
    wait_out(1, 9);
    checks++;
    if (got1.size() != 9) begin errors++; $display("FAIL %s_count: got %0d want 9", name, got1.size()); end
    for (int p = 0; p < 9; p++) begin
      logic [20:0] g;
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s_val[%0d]: got %h want %h", name, p, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int i = 0; i < 6; i++) drive(3'b001, 16'h0500, {9{16'h0100}}, 16'h0100);
    @(posedge clk); #1;
    rst_n = 1'b0; v1 = 1'b0;
    #1;
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midreset_ov: got %b want 0", ov1); end
    checks++; if (s1 !== 21'd0) begin errors++; $display("FAIL midreset_sum: got %0d want 0", s1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 9; i++) frame_d[i] = 16'h0100;
    send_frame1(0, {9{16'h0100}}, 16'h0000);
    wait_out(1, 9);
    checks++;
    if (got1.size() != 9) begin errors++; $display("FAIL midreset_count: got %0d want 9", got1.size()); end
    for (int p = 0; p < 9; p++) begin
      logic [20:0] g;
      g = (p < got1.size()) ? got1[p] : 21'bx;
      checks++;
      if (g !== 21'(basic_exp[p])) begin
        errors++; $display("FAIL midreset_val[%0d]: got %0d want %0d", p, $signed(g), basic_exp[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f2_first;
    clear_q();
    for (int i = 0; i < 36; i++) drive(3'b100, 16'h0100, {9{16'(((i % 4) + 1) * 256)}}, 16'h0000);
    // Flush window: these samples must be ignored and must not touch the parameter store.
    for (int i = 0; i < 16; i++) drive(3'b100, 16'h7FFF, 144'd0, 16'h7FFF);
    f2_first = 0;
    for (int i = 0; i < 36; i++) begin
      drive(3'b100, 16'h0100, {9{16'((4 - (i % 4)) * 256)}}, 16'((i % 4) * 256));
      if (i == 16) f2_first = cyc + 1;
    end
    idle(1);
    wait_out(4, 72);
    for (int p = 0; p < 36; p++) exp_q.push_back(21'(nvalid[p / 4] * 256 * ((p % 4) + 1)));
    for (int p = 0; p < 36; p++) exp_q.push_back(21'(nvalid[p / 4] * 256 * (4 - (p % 4)) + 256 * (p % 4)));
    checks++;
    if (got4.size() != 72) begin errors++; $display("FAIL b2b_count: got %0d want 72", got4.size()); end
    for (int p = 0; p < 72; p++) begin
      logic [20:0] e, g;
      e = exp_q.pop_front();
      g = (p < got4.size()) ? got4[p] : 21'bx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_val[%0d]: got %0d want %0d", p, $signed(g), $signed(e)); end
    end
    checks++;
    if (st4.size() < 37 || st4[36] != f2_first) begin
      errors++; $display("FAIL b2b_f2_latency: got %0d want %0d", (st4.size() > 36) ? st4[36] : -1, f2_first);
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing(0, "basic");
    test_frame_timing(2, "gaps");
    test_taps();
    test_bias();
    test_arith(16'h7FFF, 16'h7FFF, 21'h0FFFFF, "sat_pos");
    test_arith(16'h8000, 16'h7FFF, 21'h100000, "sat_neg");
    test_arith(16'hFFFF, 16'h0001, 21'h1FFFFF, "floor");
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dwconv_engine.md
DWCONV_ENGINE -- requirements
Module: dwconv_engine

Interface
REQ-001 Parameter CHANNELS, default 256: depthwise channel count; input and output channel counts are equal.
REQ-002 Parameter IMG_W, default 14: feature-map width in pixels.
REQ-003 Parameter IMG_H, default 14: feature-map height in pixels.
REQ-004 Parameter FRAC_BITS, default 8: fractional bits of in_data, weight and bias (Q7.8 at default).
REQ-005 Port clk, input, 1: single clock, rising-edge active.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port in_valid, input, 1: in_data/weight/bias valid this cycle.
REQ-008 Port in_data, input, 16: signed activation sample.
REQ-009 Port bias, input, 16: bias for the sample's channel, interpreted as two's complement.
REQ-010 Port weight, input, 144: nine signed 16-bit taps; tap k = weight[16k+15:16k], k = 3*dy+dx; dy/dx 0..2 = row/column offset -1..+1.
REQ-011 Port out_valid, output, 1: sum valid this cycle.
REQ-012 Port sum, output, 21: signed convolution result.

Function
REQ-013 Input order shall be raster, pixel-major and channel-minor: flat index i = (row*IMG_W + col)*CHANNELS + ch; one sample per accepted cycle.
REQ-014 Weights and bias shall accompany every sample and apply to that sample's channel; on each accepted sample the block shall write them into a per-channel parameter store of CHANNELS entries.
REQ-015 in_valid gaps shall be allowed; a low in_valid shall not advance any counter outside FLUSH.
REQ-016 States: IDLE (no frame), FILL (fewer than (IMG_W+1)*CHANNELS samples accepted), RUN (one output per accepted sample), FLUSH (drain after the last sample).
REQ-017 Transitions: IDLE->FILL on the first accepted sample; FILL->RUN when sample (IMG_W+1)*CHANNELS-1 is accepted; RUN->FLUSH when sample IMG_H*IMG_W*CHANNELS-1 is accepted; FLUSH->IDLE after the last output.
REQ-018 Output for pixel (r,c), channel ch shall be sum over dy,dx of x(r+dy-1, c+dx-1, ch)*tap[3dy+dx], where x is 0 outside the map (same-size zero padding, stride 1).
REQ-019 Outputs shall be emitted in the same flat order as inputs, exactly IMG_H*IMG_W*CHANNELS per frame.
REQ-020 In FILL/RUN, output index p shall appear (out_valid=1, registered) the cycle after input index p+(IMG_W+1)*CHANNELS is accepted.
REQ-021 In FLUSH, the remaining (IMG_W+1)*CHANNELS outputs shall appear on consecutive cycles regardless of in_valid, using the stored weights and bias, with zero for all missing rows.
REQ-022 in_valid asserted during FLUSH shall be ignored; a new frame shall begin only from IDLE.
REQ-023 Column padding at c=0 and c=IMG_W-1 and row padding at r=0 and r=IMG_H-1 shall be applied by index masking, never from stale buffer contents.
REQ-024 Arithmetic: 32-bit products; 36-bit accumulator acc = sum of products + (sign-extended bias << FRAC_BITS).
REQ-025 sum = acc >>> FRAC_BITS (arithmetic shift, truncate toward -inf), saturated to [-1048576, 1048575].
REQ-026 When out_valid=0, sum shall hold its previous value.

Reset
REQ-027 While rst_n=0: state=IDLE, all counters=0, out_valid=0, sum=0, asynchronously.
REQ-028 Reset mid-frame shall discard all buffered samples and outputs; the first sample accepted after release shall be treated as pixel (0,0), channel 0.
REQ-029 The parameter store and line buffer need not be cleared on reset; REQ-023 masking guarantees correctness.

Verification (CHANNELS=1, IMG_W=3, IMG_H=3, FRAC_BITS=8 unless noted)
REQ-030 Use 9 back-to-back samples with in_data=0x0100, all taps 0x0100 and bias 0. out_valid shall rise the cycle after sample 4. The 9 outputs in order shall be 1024,1536,1024,1536,2304,1536,1024,1536,1024. The last 4 outputs shall come on consecutive FLUSH cycles.
REQ-031 Use taps 0, bias 0x0100 and any data. Every output shall be 256. The bias-only path shall be checked with CHANNELS=2 and biases 0x0100 and 0xFF00, with outputs alternating 256 and -256.
REQ-032 Use in_data=0x7FFF with taps 0x7FFF, then in_data=0x8000 with taps 0x7FFF. Centre outputs shall saturate to 0x0FFFFF and 0x100000 respectively.
REQ-033 Repeat REQ-030 with in_valid low 2 cycles between samples. Output values shall be identical, each output shall appear one cycle after its triggering sample, and FLUSH shall still be gap-free.
REQ-034 Assert rst_n=0 after sample 6, then run a full REQ-030 frame. Outputs shall be exactly the 9 REQ-030 values, with no residue from the aborted frame.
REQ-035 Run two frames back-to-back after IDLE with CHANNELS=4. Each frame shall yield 36 outputs, and per-channel taps shall be honoured.
